// File: rtl/rvm_credit_ledger_if.sv
// Sorter, receipt-printer and status signals of the reverse-vending credit ledger.
// The ledger takes the slave modport; the sorter/printer/test side takes master.
interface rvm_credit_ledger_if;
    logic [2:0]  status_code;
    logic        bc_pulse;
    logic        cc_pulse;
    logic        receipt_req;
    logic        rcpt_ready;
    logic        rcpt_valid;
    logic [7:0]  rcpt_data;
    logic [7:0]  bottle_count;
    logic [7:0]  can_count;
    logic [11:0] credit;
    logic        proto_err;
    logic [3:0]  err_count;
    logic        busy;

    modport master (
        output status_code, bc_pulse, cc_pulse, receipt_req, rcpt_ready,
        input  rcpt_valid, rcpt_data, bottle_count, can_count, credit,
               proto_err, err_count, busy
    );

    modport slave (
        input  status_code, bc_pulse, cc_pulse, receipt_req, rcpt_ready,
        output rcpt_valid, rcpt_data, bottle_count, can_count, credit,
               proto_err, err_count, busy
    );
endinterface

// File: rtl/rvm_credit_ledger.sv
// Session ledger for a reverse vending machine: counts bottles/cans, streams a 5-byte receipt.
// Define RVM_LEDGER_PROTO_CHECK_EN to enable sorter protocol checking and pulse qualification.
module rvm_credit_ledger #(
    parameter int BOTTLE_VALUE = 10,
    parameter int CAN_VALUE    = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    rvm_credit_ledger_if.slave   bus
);

    typedef enum logic [1:0] {IDLE, TRACK, SEND} state_t;

    localparam logic [13:0] BOTTLE_INC = 14'(BOTTLE_VALUE);
    localparam logic [13:0] CAN_INC    = 14'(CAN_VALUE);

    state_t      state_q, state_d;
    logic        req_q;
    logic        valid_q;
    logic [2:0]  byte_idx_q;
    logic [7:0]  bottle_q, can_q;
    logic [11:0] credit_q;
    logic [7:0]  snap_bottle_q, snap_can_q;
    logic [11:0] snap_credit_q;

    logic        start_send, last_xfer, xfer;
    logic        bottle_acc, can_acc;
    logic [7:0]  bottle_base, can_base, bottle_d, can_d;
    logic [11:0] credit_base, credit_d;
    logic [13:0] credit_sum;

    assign start_send = (state_q != SEND) && bus.receipt_req && !req_q && (bus.status_code == 3'd0);
    assign xfer       = (state_q == SEND) && valid_q && bus.rcpt_ready;
    assign last_xfer  = xfer && (byte_idx_q == 3'd4);

`ifdef RVM_LEDGER_PROTO_CHECK_EN
    logic [2:0] prev_code_q;
    logic       proto_err_q;
    logic [3:0] err_count_q;
    logic       violation;

    function automatic logic legal_step(input logic [2:0] p, input logic [2:0] c);
        case (p)
            3'd0:    legal_step = (c == 3'd0) || (c == 3'd1);
            3'd1:    legal_step = (c >= 3'd1) && (c <= 3'd4);
            3'd2:    legal_step = (c == 3'd2) || (c == 3'd5);
            3'd3:    legal_step = (c == 3'd3) || (c == 3'd5);
            3'd4:    legal_step = (c == 3'd4) || (c == 3'd5);
            3'd5:    legal_step = (c == 3'd5) || (c == 3'd0);
            default: legal_step = 1'b0;
        endcase
    endfunction

    assign bottle_acc = bus.bc_pulse && !bus.cc_pulse && (bus.status_code == 3'd3);
    assign can_acc    = bus.cc_pulse && !bus.bc_pulse && (bus.status_code == 3'd2);
    // Illegal codes 6/7 fail legal_step as both destination and source.
    assign violation  = !legal_step(prev_code_q, bus.status_code)
                      || (bus.bc_pulse && !bottle_acc)
                      || (bus.cc_pulse && !can_acc);

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_code_q <= 3'd0;
            proto_err_q <= 1'b0;
            err_count_q <= 4'd0;
        end else begin
            prev_code_q <= bus.status_code;
            proto_err_q <= violation;
            if (violation && err_count_q != 4'hF)
                err_count_q <= err_count_q + 4'd1;
        end
    end

    assign bus.proto_err = proto_err_q;
    assign bus.err_count = err_count_q;
`else
    assign bottle_acc    = bus.bc_pulse;
    assign can_acc       = bus.cc_pulse;
    assign bus.proto_err = 1'b0;
    assign bus.err_count = 4'd0;
`endif

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start_send) state_d = SEND;
                     else if (bus.status_code != 3'd0) state_d = TRACK;
            TRACK:   if (start_send) state_d = SEND;
                     else if (bus.status_code == 3'd0) state_d = IDLE;
            SEND:    if (last_xfer) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A session clears on SEND entry; a pulse accepted that same cycle opens the new one.
    always_comb begin
        bottle_base = start_send ? 8'd0  : bottle_q;
        can_base    = start_send ? 8'd0  : can_q;
        credit_base = start_send ? 12'd0 : credit_q;
        bottle_d    = (bottle_acc && bottle_base != 8'hFF) ? bottle_base + 8'd1 : bottle_base;
        can_d       = (can_acc    && can_base    != 8'hFF) ? can_base    + 8'd1 : can_base;
        credit_sum  = {2'b00, credit_base}
                    + (bottle_acc ? BOTTLE_INC : 14'd0)
                    + (can_acc    ? CAN_INC    : 14'd0);
        credit_d    = (credit_sum > 14'd4095) ? 12'hFFF : credit_sum[11:0];
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            req_q         <= 1'b0;
            valid_q       <= 1'b0;
            byte_idx_q    <= 3'd0;
            bottle_q      <= 8'd0;
            can_q         <= 8'd0;
            credit_q      <= 12'd0;
            snap_bottle_q <= 8'd0;
            snap_can_q    <= 8'd0;
            snap_credit_q <= 12'd0;
        end else begin
            state_q  <= state_d;
            req_q    <= bus.receipt_req;
            bottle_q <= bottle_d;
            can_q    <= can_d;
            credit_q <= credit_d;
            if (start_send) begin
                snap_bottle_q <= bottle_q;
                snap_can_q    <= can_q;
                snap_credit_q <= credit_q;
                byte_idx_q    <= 3'd0;
                valid_q       <= 1'b1;
            end else if (xfer) begin
                if (last_xfer) begin
                    byte_idx_q <= 3'd0;
                    valid_q    <= 1'b0;
                end else begin
                    byte_idx_q <= byte_idx_q + 3'd1;
                end
            end
        end
    end

    always_comb begin
        bus.rcpt_data = 8'h00;
        if (valid_q) begin
            case (byte_idx_q)
                3'd0:    bus.rcpt_data = 8'hA5;
                3'd1:    bus.rcpt_data = snap_bottle_q;
                3'd2:    bus.rcpt_data = snap_can_q;
                3'd3:    bus.rcpt_data = {4'h0, snap_credit_q[11:8]};
                3'd4:    bus.rcpt_data = snap_credit_q[7:0];
                default: bus.rcpt_data = 8'h00;
            endcase
        end
    end

    assign bus.rcpt_valid   = valid_q;
    assign bus.bottle_count = bottle_q;
    assign bus.can_count    = can_q;
    assign bus.credit       = credit_q;
    assign bus.busy         = (state_q == SEND);

endmodule
